// File: rtl/dot_product_engine_pkg.sv
// Shared Q-format constants and FSM state type for the dot-product engine
// and the full-connect layers that consume its Q1.14 results.
package dot_product_engine_pkg;

  localparam int OPR_W   = 8;    // Q1.7 operand
  localparam int PROD_W  = 16;   // Q2.14 product
  localparam int SUM_W   = 15;   // Q1.14 result
  localparam int VEC_LEN = 128;  // elements per vector

  // Q1.14 saturation limits, also used for bias alignment in the FC layers
  localparam logic [SUM_W-1:0] SUM_SAT_POS = 15'h3FFF;
  localparam logic [SUM_W-1:0] SUM_SAT_NEG = 15'h4000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FIN   = 2'd2
  } dp_state_t;

endpackage

// File: rtl/mac_lane_tree.sv
// Combinational beat datapath: LANES signed 8x8 multipliers feeding a
// pairwise adder tree. Every tree node is ACC_W wide, so the beat sum is
// exact. LANES must be a power of two.
module mac_lane_tree
  import dot_product_engine_pkg::*;
#(
  parameter int LANES = 16,
  parameter int ACC_W = 23
) (
  input  logic [LANES*OPR_W-1:0] a_beat,
  input  logic [LANES*OPR_W-1:0] b_beat,
  output logic [ACC_W-1:0]       beat_sum
);

  logic signed [OPR_W-1:0]  a_el [LANES];
  logic signed [OPR_W-1:0]  b_el [LANES];
  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0]  node [LANES];

  // multiply each lane, sign-extend, then fold the tree level by level
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      a_el[j] = a_beat[j*OPR_W +: OPR_W];
      b_el[j] = b_beat[j*OPR_W +: OPR_W];
      prod[j] = PROD_W'(a_el[j]) * PROD_W'(b_el[j]);
      node[j] = ACC_W'(prod[j]);
    end
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        node[j] = node[2*j] + node[2*j+1];
      end
    end
    beat_sum = node[0];
  end

endmodule

// File: rtl/dot_product_engine.sv
// Responder side of the MultAdder interface: sequential dot product of two
// Q1.7 vectors, LANES products per cycle, Q1.14 result with overflow flag.
// Build option: define DOT_SAT_EN to saturate oSum on overflow; otherwise
// oSum is the low 15 accumulator bits (wrap). oOverflow is the same either way.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for iStart; operands latched when it arrives
// ST_ACCUM | one beat (LANES products) accumulated per enabled cycle
// ST_FIN   | oValid high, result registers new; iStart relatches here
module dot_product_engine
  import dot_product_engine_pkg::*;
#(
  parameter int N_ELEM = VEC_LEN,
  parameter int LANES  = 16,
  parameter int ACC_W  = 23
) (
  input  logic                    clk,
  input  logic                    iRst_n,
  input  logic                    ena,
  input  logic                    iStart,
  input  logic [N_ELEM*OPR_W-1:0] iOpr1,
  input  logic [N_ELEM*OPR_W-1:0] iOpr2,
  output logic                    oBusy,
  output logic                    oValid,
  output logic [SUM_W-1:0]        oSum,
  output logic                    oOverflow
);

  localparam int N_BEATS   = N_ELEM / LANES;
  localparam int BEAT_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int LANE_BITS = LANES * OPR_W;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N_BEATS - 1);
  localparam logic signed [ACC_W-1:0] ACC_HI = {{(ACC_W-SUM_W){1'b0}}, SUM_SAT_POS};
  localparam logic signed [ACC_W-1:0] ACC_LO = {{(ACC_W-SUM_W){1'b1}}, SUM_SAT_NEG};

  dp_state_t                state, state_nxt;
  logic [N_ELEM*OPR_W-1:0]  opr1_q, opr2_q;
  logic signed [ACC_W-1:0]  acc, acc_nxt, beat_sum;
  logic [BEAT_W-1:0]        beat;
  logic                     start_take, last_beat, sum_ovf;
  logic [SUM_W-1:0]         sum_conv;

  // operands shift down one beat per cycle, so the tree always sees the low slice
  mac_lane_tree #(.LANES(LANES), .ACC_W(ACC_W)) u_tree (
    .a_beat   (opr1_q[LANE_BITS-1:0]),
    .b_beat   (opr2_q[LANE_BITS-1:0]),
    .beat_sum (beat_sum)
  );

  assign acc_nxt    = acc + beat_sum;
  assign last_beat  = (beat == BEAT_LAST);
  assign start_take = iStart && ((state == ST_IDLE) || (state == ST_FIN));
  assign sum_ovf    = (acc_nxt > ACC_HI) || (acc_nxt < ACC_LO);

  // state register; ena=0 freezes the FSM
  always_ff @(posedge clk) begin
    if (!iRst_n)  state <= ST_IDLE;
    else if (ena) state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (iStart)    state_nxt = ST_ACCUM;
      ST_ACCUM: if (last_beat) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = iStart ? ST_ACCUM : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    oBusy  = (state == ST_ACCUM);
    oValid = (state == ST_FIN);
  end

  // Q1.14 conversion of the final accumulator value (the one entering FIN)
  always_comb begin
`ifdef DOT_SAT_EN
    if (acc_nxt > ACC_HI)      sum_conv = SUM_SAT_POS;
    else if (acc_nxt < ACC_LO) sum_conv = SUM_SAT_NEG;
    else                       sum_conv = acc_nxt[SUM_W-1:0];
`else
    sum_conv = acc_nxt[SUM_W-1:0];
`endif
  end

  // operand registers: latch on start, shift one beat per accumulate cycle
  always_ff @(posedge clk) begin
    if (ena) begin
      if (start_take) begin
        opr1_q <= iOpr1;
        opr2_q <= iOpr2;
      end else if (state == ST_ACCUM) begin
        opr1_q <= opr1_q >> LANE_BITS;
        opr2_q <= opr2_q >> LANE_BITS;
      end
    end
  end

  // accumulator, beat counter and result registers; results load on the last beat
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      acc       <= '0;
      beat      <= '0;
      oSum      <= '0;
      oOverflow <= 1'b0;
    end else if (ena) begin
      if (start_take) begin
        acc  <= '0;
        beat <= '0;
      end else if (state == ST_ACCUM) begin
        acc  <= acc_nxt;
        beat <= beat + BEAT_W'(1);
        if (last_beat) begin
          oSum      <= sum_conv;
          oOverflow <= sum_ovf;
        end
      end
    end
  end

endmodule
